aes_shift_rows_pipe: RTL and testbench

Registered, handshaked ShiftRows/InvShiftRows stage for the AES datapath, generalised to Rijndael block widths of 128, 192 and 256 bits (NB = 4, 6, 8 columns). Each transfer selects forward or inverse shift, so one instance serves both the encrypt and decrypt round pipelines. A tag field travels with the data. The stage sits between SubBytes and MixColumns and uses valid/ready flow control on both sides.

---
 rtl/aes_shift_rows_pipe.sv | 190 +++++++++++++++++++
 tb/tb_aes_shift_rows_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// aes_shift_rows_pipe
//
// A registered ShiftRows / InvShiftRows stage for Rijndael states of NB
// columns (NB = 4, 6 or 8, i.e. 128/192/256-bit blocks). The direction is
// chosen per beat, so one instance can serve both the encrypt and decrypt
// round pipelines. The permutation is pure wiring in front of the output
// register, so no path runs combinationally from in_* to out_*.
//
// Parameters
//   NB     state columns (4, 6 or 8)
//   TAG_W  sideband tag width (>= 1)
//   W      derived data width, 32*NB
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous discard of every held beat
//   in_valid / in_ready   input handshake
//   in_inv                0: ShiftRows, 1: InvShiftRows
//   in_tag, in_data       beat tag and state (byte k = r+4c at [W-1-8k -: 8])
//   out_valid / out_ready output handshake
//   out_tag, out_data     registered tag and shifted state
//
// Build option
//   AES_SHIFT_ROWS_SKID_EN  adds a skid slot so in_ready comes from a flop
//                           and has no combinational path from out_ready.
//                           Undefined: single output slot, in_ready follows
//                           out_ready combinationally.
// ---------------------------------------------------------------------------

// One state row: rotate NB bytes left (forward) or right (inverse) by SHIFT.
// Ports: row_in  bytes of the row, index = column
//        inv     rotation direction
//        row_out rotated row
module aes_shift_rows_row #(
    parameter int NB    = 4,
    parameter int SHIFT = 0
) (
    input  logic [NB-1:0][7:0] row_in,
    input  logic               inv,
    output logic [NB-1:0][7:0] row_out
);

    for (genvar c = 0; c < NB; c++) begin : g_col
        // Both candidates are fixed taps, so this is a 2:1 byte mux per column.
        assign row_out[c] = inv ? row_in[(c - SHIFT + NB) % NB]
                                : row_in[(c + SHIFT) % NB];
    end

endmodule

module aes_shift_rows_pipe #(
    parameter  int NB    = 4,
    parameter  int TAG_W = 4,
    localparam int W     = 32 * NB
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inv,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [W-1:0]     out_data
);

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("aes_shift_rows_pipe: TAG_W must be at least 1");
    end

    // Rijndael row offsets: {0,1,2,3} for NB=4/6, {0,1,3,4} for NB=8.
    function automatic int row_shift(input int r);
        if (r == 0) return 0;
        if (NB == 8) return (r == 1) ? 1 : r + 1;
        return r;
    endfunction

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     data;
    } beat_t;

    // -----------------------------------------------------------------------
    // Permutation: unpack column-major bytes into rows, rotate, repack.
    // -----------------------------------------------------------------------
    logic [3:0][NB-1:0][7:0] rows_in;
    logic [3:0][NB-1:0][7:0] rows_out;
    logic [W-1:0]            perm_data;

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_byte
            assign rows_in[r][c]                      = in_data[W-1-8*(r+4*c) -: 8];
            assign perm_data[W-1-8*(r+4*c) -: 8]      = rows_out[r][c];
        end

        aes_shift_rows_row #(
            .NB    (NB),
            .SHIFT (row_shift(r))
        ) u_row (
            .row_in  (rows_in[r]),
            .inv     (in_inv),
            .row_out (rows_out[r])
        );
    end

    beat_t in_beat;
    beat_t out_q;
    logic  out_valid_q;
    logic  accept;

    assign in_beat.tag  = in_tag;
    assign in_beat.data = perm_data;

`ifdef AES_SHIFT_ROWS_SKID_EN
    // -----------------------------------------------------------------------
    // Two slots. in_ready only looks at the skid flop, cutting the
    // out_ready -> in_ready path. A beat arriving while the output slot is
    // stalled parks in the skid slot, which then blocks further input until
    // the next take moves it forward.
    // -----------------------------------------------------------------------
    logic  skid_valid;
    beat_t skid_q;
    logic  out_free;

    assign in_ready = !flush && !skid_valid;
    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_valid  <= 1'b0;
            skid_q      <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            skid_valid  <= 1'b0;
        end else if (out_free) begin
            // Skid content is older than anything on the input, drain it
            // first. accept is necessarily low while skid_valid is set.
            if (skid_valid) begin
                out_q       <= skid_q;
                out_valid_q <= 1'b1;
                skid_valid  <= 1'b0;
            end else if (accept) begin
                out_q       <= in_beat;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= in_beat;
            skid_valid <= 1'b1;
        end
    end
`else
    // -----------------------------------------------------------------------
    // Single slot. Take and accept in the same cycle overwrite the slot,
    // which gives one beat per cycle under continuous out_ready.
    // -----------------------------------------------------------------------
    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_q       <= in_beat;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign out_tag   = out_q.tag;
    assign out_data  = out_q.data;

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// tb_aes_shift_rows_pipe
//
// Directed bench for aes_shift_rows_pipe. Three instances (NB = 4, 6, 8)
// share every control input and differ only in data width, so one stimulus
// sequence exercises all three block sizes in lock-step. Handshake,
// backpressure, flush and reset behaviour is observed on the NB=4 instance.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_aes_shift_rows_pipe;

    localparam int TW = 4;

    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_inv, out_ready;
    logic [TW-1:0] in_tag;
    logic [127:0]  in_d4;
    logic [191:0]  in_d6;
    logic [255:0]  in_d8;

    logic          rdy4, rdy6, rdy8, ov4, ov6, ov8;
    logic [TW-1:0] ot4, ot6, ot8;
    logic [127:0]  od4;
    logic [191:0]  od6;
    logic [255:0]  od8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    aes_shift_rows_pipe #(.NB(4), .TAG_W(TW)) u_nb4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy4), .in_inv(in_inv), .in_tag(in_tag), .in_data(in_d4),
        .out_valid(ov4), .out_ready(out_ready), .out_tag(ot4), .out_data(od4)
    );

    aes_shift_rows_pipe #(.NB(6), .TAG_W(TW)) u_nb6 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy6), .in_inv(in_inv), .in_tag(in_tag), .in_data(in_d6),
        .out_valid(ov6), .out_ready(out_ready), .out_tag(ot6), .out_data(od6)
    );

    aes_shift_rows_pipe #(.NB(8), .TAG_W(TW)) u_nb8 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy8), .in_inv(in_inv), .in_tag(in_tag), .in_data(in_d8),
        .out_valid(ov8), .out_ready(out_ready), .out_tag(ot8), .out_data(od8)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // Present one beat to all three instances; returns on the falling edge
    // after the accepting rising edge, with in_valid dropped.
    task automatic push(input logic inv, input logic [TW-1:0] tg,
                        input logic [127:0] a, input logic [191:0] b, input logic [255:0] c);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_inv   = inv;
        in_tag   = tg;
        in_d4    = a;
        in_d6    = b;
        in_d8    = c;
        #1;
        while (!rdy4 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("push_accept", rdy4, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Row-constant pattern: byte (r,c) = {t, r}; any row rotation leaves it
    // unchanged, so it tracks beat identity independent of direction.
    function automatic logic [127:0] rowpat(input logic [3:0] t);
        logic [127:0] v;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                v[127-8*(r+4*c) -: 8] = {t, 4'(r)};
        return v;
    endfunction

    logic [127:0] idx4, r4, f4;
    logic [191:0] idx6, r6, f6;
    logic [255:0] idx8, r8, f8;
    logic [63:0]  row2, row3;
    logic [TW-1:0] tg;

    int           prod_i, prod_guard, cons_got, cons_cyc;
    logic         cons_stalled, cons_ir0;
    logic [TW-1:0] cons_ht;
    logic [127:0] cons_hd;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no completion expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b1;
        in_tag = '0; in_d4 = '0; in_d6 = '0; in_d8 = '0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("rst_out_valid", ov4, 1'b0);
        chk("rst_out_data",  od4, 128'h0);
        chk("rst_out_tag",   ot4, 4'h0);
        chk("rst_out_data8", od8, 256'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",    rdy4, 1'b1);
        chk("rst_in_ready_68", {rdy6, rdy8}, 2'b11);

        // ---- FIPS-197 forward and inverse ----
        push(1'b0, 4'h3, FIPS_IN, '0, '0);
        chk("fips_fwd_valid", ov4, 1'b1);
        chk("fips_fwd_data",  od4, FIPS_OUT);
        chk("fips_fwd_tag",   ot4, 4'h3);
        push(1'b1, 4'h9, FIPS_OUT, '0, '0);
        chk("fips_inv_data",  od4, FIPS_IN);
        chk("fips_inv_tag",   ot4, 4'h9);

        // ---- byte k = k, forward, all three widths ----
        for (int k = 0; k < 16; k++) idx4[127-8*k -: 8] = 8'(k);
        for (int k = 0; k < 24; k++) idx6[191-8*k -: 8] = 8'(k);
        for (int k = 0; k < 32; k++) idx8[255-8*k -: 8] = 8'(k);
        push(1'b0, 4'h1, idx4, idx6, idx8);
        chk("idx_fwd_nb4", od4, 128'h00050a0f_04090e03_080d0207_0c01060b);
        chk("idx_fwd_nb6", od6, 192'h00050a0f_04090e13_080d1217_0c111603_10150207_1401060b);
        chk("idx_fwd_nb8", od8, 256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f);
        for (int c = 0; c < 8; c++) begin
            row2[63-8*c -: 8] = od8[255-8*(2+4*c) -: 8];
            row3[63-8*c -: 8] = od8[255-8*(3+4*c) -: 8];
        end
        chk("nb8_row2", row2, 64'h0e12161a1e02060a);
        chk("nb8_row3", row3, 64'h13171b1f03070b0f);

        // ---- random forward/inverse round trips ----
        for (int it = 0; it < 1000; it++) begin
            for (int w = 0; w < 4; w++) r4[32*w +: 32] = $urandom();
            for (int w = 0; w < 6; w++) r6[32*w +: 32] = $urandom();
            for (int w = 0; w < 8; w++) r8[32*w +: 32] = $urandom();
            tg = 4'(it);
            push(1'b0, tg, r4, r6, r8);
            f4 = od4; f6 = od6; f8 = od8;
            push(1'b1, ~tg, f4, f6, f8);
            chk("rt_nb4", od4, r4);
            chk("rt_nb6", od6, r6);
            chk("rt_nb8", od8, r8);
            chk("rt_valid_68", {ov6, ov8}, 2'b11);
            chk("rt_tag_68", {ot6, ot8}, {~tg, ~tg});
        end

        // ---- backpressure: 8 tagged beats, random out_ready ----
        prod_i = 0; prod_guard = 0; cons_got = 0; cons_cyc = 0; cons_stalled = 1'b0;
        fork
            begin
                while (prod_i < 8 && prod_guard < 400) begin
                    @(negedge clk);
                    in_valid = 1'b1;
                    in_tag   = 4'(prod_i);
                    in_inv   = prod_i[0];
                    in_d4    = rowpat(4'(prod_i));
                    #3;
                    if (rdy4) prod_i++;
                    prod_guard++;
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                while (cons_got < 8 && cons_cyc < 400) begin
                    @(negedge clk);
                    cons_cyc++;
                    if (cons_stalled) begin
                        chk("bp_stall_valid", ov4, 1'b1);
                        chk("bp_stall_tag",   ot4, cons_ht);
                        chk("bp_stall_data",  od4, cons_hd);
                    end
                    cons_ir0  = rdy4;
                    out_ready = ($urandom_range(0, 2) != 0);
`ifdef AES_SHIFT_ROWS_SKID_EN
                    #1;
                    chk("bp_in_ready_decoupled", rdy4, cons_ir0);
`endif
                    if (ov4 && out_ready) begin
                        chk("bp_tag_order", ot4, 4'(cons_got));
                        chk("bp_data",      od4, rowpat(4'(cons_got)));
                        cons_got++;
                    end
                    cons_stalled = ov4 && !out_ready;
                    cons_ht      = ot4;
                    cons_hd      = od4;
                end
                chk("bp_count", cons_got, 8);
            end
        join
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("bp_no_dup", ov4, 1'b0);

        // ---- flush with held beat(s) and a competing input ----
        out_ready = 1'b0;
        push(1'b0, 4'ha, FIPS_IN, '0, '0);
`ifdef AES_SHIFT_ROWS_SKID_EN
        push(1'b0, 4'hb, idx4, '0, '0);
        #1;
        chk("flush_skid_full_ready", rdy4, 1'b0);
`else
        #1;
        chk("flush_stalled_ready", rdy4, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("comb_ready_follows_out_ready", rdy4, 1'b1);
        out_ready = 1'b0;
`endif
        chk("flush_held_valid", ov4, 1'b1);
        chk("flush_held_tag",   ot4, 4'ha);
        @(negedge clk);
        chk("stall_data_stable", od4, FIPS_OUT);
        chk("stall_tag_stable",  ot4, 4'ha);
        in_valid = 1'b1; in_tag = 4'hc; in_inv = 1'b0; in_d4 = idx4; flush = 1'b1;
        #1;
        chk("flush_in_ready", rdy4, 1'b0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", ov4, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_nothing_left", ov4, 1'b0);

        // ---- asynchronous reset mid-stream ----
        out_ready = 1'b0;
        push(1'b0, 4'h5, FIPS_IN, '0, '0);
        chk("mid_rst_held", ov4, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", ov4, 1'b0);
        chk("mid_rst_data",  od4, 128'h0);
        chk("mid_rst_tag",   ot4, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", rdy4, 1'b1);
        chk("rel_valid",    ov4, 1'b0);
        out_ready = 1'b1;
        push(1'b1, 4'h6, FIPS_OUT, '0, '0);
        chk("post_rst_valid", ov4, 1'b1);
        chk("post_rst_data",  od4, FIPS_IN);
        chk("post_rst_tag",   ot4, 4'h6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
